// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner that snapshots its inputs once per frame and scans digits left to right.
// Defining SEG_LZ_BLANK_EN turns on leading-zero blanking; without it every zero nibble shows as 0.
module seg_scan #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   data,
   input  logic                  neg,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic [DIGITS-1:0]     blank_mask,
   output logic [7:0]            segs,
   output logic [DIGITS-1:0]     AN,
   output logic                  frame_start
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int POS_W = $clog2(DIGITS);

   logic [DIV_W-1:0]    r_divCnt;
   logic [POS_W-1:0]    r_pos;
   logic [4*DIGITS-1:0] r_fData;
   logic                r_fNeg;
   logic [DIGITS-1:0]   r_fDp;
   logic [DIGITS-1:0]   r_fBlank;
   logic [7:0]          r_segs;
   logic [DIGITS-1:0]   r_an;
   logic                r_frameStart;

   logic                w_tick;
   logic                w_isTop;
   logic [3:0]          w_nib;
   logic                w_dp;
   logic                w_blank;
   logic                w_lzBlank;
   logic [6:0]          w_glyph;
   logic [DIGITS-1:0]   w_an;
   logic [7:0]          w_segNext;

   function automatic logic [6:0] hexGlyph(input logic [3:0] n);
      case (n)
         4'h0: hexGlyph = 7'b0000001;
         4'h1: hexGlyph = 7'b1001111;
         4'h2: hexGlyph = 7'b0010010;
         4'h3: hexGlyph = 7'b0000110;
         4'h4: hexGlyph = 7'b1001100;
         4'h5: hexGlyph = 7'b0100100;
         4'h6: hexGlyph = 7'b0100000;
         4'h7: hexGlyph = 7'b0001111;
         4'h8: hexGlyph = 7'b0000000;
         4'h9: hexGlyph = 7'b0000100;
         4'hA: hexGlyph = 7'b0001000;
         4'hB: hexGlyph = 7'b1100000;
         4'hC: hexGlyph = 7'b0110001;
         4'hD: hexGlyph = 7'b1000010;
         4'hE: hexGlyph = 7'b0110000;
         default: hexGlyph = 7'b0111000;
      endcase
   endfunction

   assign w_tick  = (r_divCnt == DIV_W'(SCAN_DIV - 1));
   assign w_isTop = (r_pos == POS_W'(DIGITS - 1));

   // Everything the display shows comes from the frame snapshot, never the live inputs.
   always_comb begin
      w_nib   = '0;
      w_dp    = 1'b0;
      w_blank = 1'b0;
      w_an    = '1;
      for (int p = 0; p < DIGITS; p++) begin
         if (r_pos == POS_W'(p)) begin
            w_nib    = r_fData[4*p +: 4];
            w_dp     = r_fDp[p];
            w_blank  = r_fBlank[p];
            w_an[p]  = 1'b0;
         end
      end
      w_glyph = (w_isTop && r_fNeg) ? 7'b1111110 : hexGlyph(w_nib);
   end

`ifdef SEG_LZ_BLANK_EN
   logic w_allZero;

   // A minus sign on the top digit counts as "zero" so the digits below it still blank.
   always_comb begin
      w_allZero = 1'b1;
      w_lzBlank = 1'b0;
      for (int p = DIGITS - 1; p >= 1; p--) begin
         w_allZero = w_allZero &&
                     ((r_fData[4*p +: 4] == 4'h0) || ((p == DIGITS - 1) && r_fNeg));
         if ((r_pos == POS_W'(p)) && w_allZero && !r_fDp[p] &&
             !((p == DIGITS - 1) && r_fNeg)) begin
            w_lzBlank = 1'b1;
         end
      end
   end
`else
   assign w_lzBlank = 1'b0;
`endif

   assign w_segNext = (w_blank || w_lzBlank) ? 8'hFF : {w_glyph, ~w_dp};

   // Dwell divider, position pointer, frame snapshot and registered display outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_divCnt     <= '0;
         r_pos        <= POS_W'(DIGITS - 1);
         r_fData      <= '0;
         r_fNeg       <= 1'b0;
         r_fDp        <= '0;
         r_fBlank     <= '0;
         r_frameStart <= 1'b0;
         r_an         <= '1;
         r_segs       <= 8'hFF;
      end else begin
         r_divCnt     <= w_tick ? '0 : r_divCnt + DIV_W'(1);
         r_frameStart <= w_tick && (r_pos == '0);
         if (w_tick) begin
            if (r_pos == '0) begin
               r_pos    <= POS_W'(DIGITS - 1);
               r_fData  <= data;
               r_fNeg   <= neg;
               r_fDp    <= dp_mask;
               r_fBlank <= blank_mask;
            end else begin
               r_pos <= r_pos - POS_W'(1);
            end
         end
         r_an   <= en ? w_an : '1;
         r_segs <= en ? w_segNext : 8'hFF;
      end
   end

   assign segs        = r_segs;
   assign AN          = r_an;
   assign frame_start = r_frameStart;

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digit positions (legal 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 100000, clock cycles per digit dwell (legal >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  display enable; 0 blanks all digits.
REQ-006 SHALL have port data  input  4*DIGITS  hex nibbles; position p = data[4p+3:4p], p = DIGITS-1 is leftmost.
REQ-007 SHALL have port neg  input  1  1 = leftmost position shows minus glyph instead of its nibble.
REQ-008 SHALL have port dp_mask  input  DIGITS  1 lights decimal point of position p.
REQ-009 SHALL have port blank_mask  input  DIGITS  1 forces position p dark.
REQ-010 SHALL have port segs  output  8  active-low {a,b,c,d,e,f,g,dp}, registered.
REQ-011 SHALL have port AN  output  DIGITS  active-low anode select, at most one bit low, registered.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse when a new frame snapshot is taken, registered.

Function
REQ-013 SHALL count div_cnt 0..SCAN_DIV-1 every cycle, wrapping to 0; tick = (div_cnt == SCAN_DIV-1).
REQ-014 SHALL hold position pointer pos; on tick pos decrements, wrapping 0 -> DIGITS-1.
REQ-015 SHALL capture data, neg, dp_mask, blank_mask into a frame register on the edge where tick and pos == 0; frame_start SHALL be 1 for exactly the following cycle.
REQ-016 SHALL drive every segment/anode decision from the frame register only, so a frame never mixes old and new inputs.
REQ-017 SHALL register outputs every cycle: AN <= all ones except AN[pos] = 0; segs <= glyph of frame position pos; one cycle latency from pos to outputs.
REQ-018 SHALL use hex glyphs (segs[7:1]): 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100, A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000.
REQ-019 SHALL show minus glyph segs[7:1] = 1111110 at position DIGITS-1 when frame neg = 1.
REQ-020 SHALL set segs[0] = 0 when frame dp_mask[pos] = 1, else 1.
REQ-021 SHALL output segs = 8'hFF (AN still selects the position) when frame blank_mask[pos] = 1; blank overrides glyph and dp.
REQ-022 SHALL, when en = 0, register AN = all ones and segs = 8'hFF; div_cnt, pos, frame capture and frame_start SHALL continue unaffected.
REQ-023 SHALL treat en changes as taking effect on outputs one cycle later, no partial-digit glitch beyond that.

Reset
REQ-024 SHALL on rst = 1 immediately force div_cnt = 0, pos = DIGITS-1, frame register = 0, AN = all ones, segs = 8'hFF, frame_start = 0.
REQ-025 SHALL, after rst release mid-frame, restart scanning at pos = DIGITS-1; first frame capture occurs at the first pos == 0 tick (frame = 0 until then, shown as zeros when en = 1).

Configuration
REQ-026 SHALL support macro SEG_LZ_BLANK_EN: when defined, position p >= 1 outputs segs = 8'hFF if frame nibbles p..DIGITS-1 are all zero and frame dp_mask[p] = 0; position DIGITS-1 with neg = 1 still shows minus, and zero blanking then applies to p..DIGITS-2; position 0 never blanked by this rule.
REQ-027 SHALL, without SEG_LZ_BLANK_EN, display all zero nibbles as glyph 0.

Verification (DIGITS=4, SCAN_DIV=4)
REQ-028 Reset release, en=1, data=16'h1234 -> after first capture, AN cycles 0111,1011,1101,1110 every 4 clocks with segs 9F,25,0D,99; frame_start pulses once per 16 clocks.
REQ-029 data changed 16'h1234 -> 16'hABCD while pos = 2 -> remaining digits of current frame still show 3,4; next frame shows 11,C1,63,85.
REQ-030 neg=1, dp_mask=4'b0010, data=16'h0057 -> leftmost segs=FD, position 1 segs=48 (5 with dp), position 0 segs=1F; with SEG_LZ_BLANK_EN position 2 segs=FF, without it 03.
REQ-031 en driven 0 for 10 cycles mid-frame -> AN=1111, segs=FF one cycle later; frame_start timing unchanged; resume shows correct digit for current pos.
REQ-032 rst asserted asynchronously between clock edges mid-scan -> AN=1111, segs=FF, frame_start=0 without a clock edge; scan restarts at AN=0111 after release.
REQ-033 blank_mask=4'b1000, dp_mask=4'b1000, data=16'h8888 -> leftmost segs=FF, others segs=01.
